// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the sc_cpu memory-mapped I/O block.
//
// Holds the default I/O window base, the register offsets inside the
// window, the CTRL field positions and the STAT bit position, plus a
// packed view of CTRL and a helper that renders it as a bus word.
// Used by mmio_io_ctrl and io_timer.
package io_pkg;

  // Default base of the 256-byte I/O window (upper 24 bits are decoded).
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

  // Register offsets (low byte of the address).
  localparam logic [7:0] OFS_LED     = 8'h00;
  localparam logic [7:0] OFS_CTRL    = 8'h04;
  localparam logic [7:0] OFS_CNT     = 8'h08;
  localparam logic [7:0] OFS_CMP     = 8'h0C;
  localparam logic [7:0] OFS_STAT    = 8'h10;
  localparam logic [7:0] OFS_SCRATCH = 8'h14;

  // CTRL bit positions.
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AR        = 1;
  localparam int CTRL_IRQ       = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  // STAT bit positions.
  localparam int STAT_MATCH = 0;

  // Stored CTRL fields; unimplemented bits are not kept.
  typedef struct packed {
    logic [7:0] presc;
    logic       irq_en;
    logic       ar;
    logic       en;
  } ctrl_t;

  // Render CTRL as the 32-bit word a load returns; unused bits read 0.
  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]  = c.en;
    w[CTRL_AR]  = c.ar;
    w[CTRL_IRQ] = c.irq_en;
    w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = c.presc;
    return w;
  endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer: prescaled 32-bit timer with compare/match flag and interrupt.
//
// Ports:
//   clk_5m, sys_rst_n   clock, asynchronous active-low reset
//   wr_ctrl/wr_cnt/
//   wr_cmp/wr_stat      one-cycle write strobes, already decoded by the top
//   wdata               store data for the strobed register
//   ctrl_rd, cnt_rd,
//   cmp_rd, stat_rd     current register contents as bus words
//   timer_irq           registered MATCH && CTRL.IRQ_EN
//
// Priority inside one cycle (later assignments in the comb block win):
//   tick update < W1C of MATCH < new match set < CTRL write < CNT write.
// A CTRL or CNT write also restarts the prescaler from 0.
module io_timer
  import io_pkg::*;
(
  input  logic        clk_5m,
  input  logic        sys_rst_n,
  input  logic        wr_ctrl,
  input  logic        wr_cnt,
  input  logic        wr_cmp,
  input  logic        wr_stat,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] cnt_rd,
  output logic [31:0] cmp_rd,
  output logic [31:0] stat_rd,
  output logic        timer_irq
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [7:0]  psc_q, psc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        cmp_eq;
  logic        match_set;

  always_comb begin
    tick      = ctrl_q.en && (psc_q == ctrl_q.presc);
    cmp_eq    = (cnt_q == cmp_q);
    match_set = tick && cmp_eq;

    ctrl_d  = ctrl_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    // Prescaler only advances while enabled; it holds otherwise.
    if (ctrl_q.en) begin
      psc_d = tick ? 8'd0 : psc_q + 8'd1;
    end

    if (tick) begin
      if (cmp_eq) begin
        if (ctrl_q.ar) begin
          cnt_d = '0;
        end else begin
          ctrl_d.en = 1'b0;      // one-shot: count holds, timer stops
        end
      end else begin
        cnt_d = cnt_q + 32'd1;   // natural wrap, no match on wrap
      end
    end

    // W1C first so that a match in the same cycle re-sets the flag.
    if (wr_stat && wdata[STAT_MATCH]) begin
      match_d = 1'b0;
    end
    if (match_set) begin
      match_d = 1'b1;
    end

    if (wr_ctrl) begin
      ctrl_d.en     = wdata[CTRL_EN];
      ctrl_d.ar     = wdata[CTRL_AR];
      ctrl_d.irq_en = wdata[CTRL_IRQ];
      ctrl_d.presc  = wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
      psc_d         = '0;
    end

    if (wr_cnt) begin
      cnt_d = wdata;
      psc_d = '0;
    end

    if (wr_cmp) begin
      cmp_d = wdata;
    end

    // Built from the next-state values so the interrupt rises on the
    // same edge as MATCH.
    irq_d = match_d && ctrl_d.irq_en;
  end

  always_ff @(posedge clk_5m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctrl_q  <= '0;
      psc_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    ctrl_rd             = ctrl_pack(ctrl_q);
    cnt_rd              = cnt_q;
    cmp_rd              = cmp_q;
    stat_rd             = '0;
    stat_rd[STAT_MATCH] = match_q;
  end

  assign timer_irq = irq_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O controller on the sc_cpu data bus.
//
// Decodes the 256-byte window at IO_BASE and holds the LED register, a
// SCRATCH register and, when the IO_TIMER_EN macro is defined, the
// io_timer block (CTRL/CNT/CMP/STAT). With IO_TIMER_EN undefined the
// timer offsets read 0, writes to them are dropped and timer_irq is 0.
//
// Ports:
//   clk_5m      system clock
//   sys_rst_n   asynchronous active-low reset
//   mem_addr    byte address from the core
//   mem_wdata   store data
//   mem_we      store strobe
//   mem_rdata   load data (combinational)
//   led         LED register contents (registered)
//   timer_irq   timer interrupt (registered)
//
// Bus protocol: there is no valid/ready handshake. A load is any cycle
// the core drives mem_addr; mem_rdata answers in the same cycle with the
// pre-edge register value. A store is a cycle with mem_we=1; it always
// completes on that cycle's rising edge (no back-pressure). Accesses
// outside the window or not word-aligned read 0 and store nothing.
module mmio_io_ctrl #(
  parameter logic [31:0] IO_BASE = io_pkg::IO_BASE,
  parameter int          LED_W   = 8
) (
  input  logic             clk_5m,
  input  logic             sys_rst_n,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_we,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  import io_pkg::*;

  logic             hit;
  logic [7:0]       ofs;
  logic             we_hit;
  logic             wr_led;
  logic             wr_scratch;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      scratch_q, scratch_d;

  assign ofs        = mem_addr[7:0];
  assign hit        = (mem_addr[31:8] == IO_BASE[31:8]) && (mem_addr[1:0] == 2'b00);
  assign we_hit     = mem_we && hit;
  assign wr_led     = we_hit && (ofs == OFS_LED);
  assign wr_scratch = we_hit && (ofs == OFS_SCRATCH);

`ifdef IO_TIMER_EN
  logic        wr_ctrl;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_stat;
  logic [31:0] ctrl_rd;
  logic [31:0] cnt_rd;
  logic [31:0] cmp_rd;
  logic [31:0] stat_rd;

  assign wr_ctrl = we_hit && (ofs == OFS_CTRL);
  assign wr_cnt  = we_hit && (ofs == OFS_CNT);
  assign wr_cmp  = we_hit && (ofs == OFS_CMP);
  assign wr_stat = we_hit && (ofs == OFS_STAT);

  io_timer u_timer (
    .clk_5m    (clk_5m),
    .sys_rst_n (sys_rst_n),
    .wr_ctrl   (wr_ctrl),
    .wr_cnt    (wr_cnt),
    .wr_cmp    (wr_cmp),
    .wr_stat   (wr_stat),
    .wdata     (mem_wdata),
    .ctrl_rd   (ctrl_rd),
    .cnt_rd    (cnt_rd),
    .cmp_rd    (cmp_rd),
    .stat_rd   (stat_rd),
    .timer_irq (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    if (wr_led) begin
      led_d = mem_wdata[LED_W-1:0];
    end
    if (wr_scratch) begin
      scratch_d = mem_wdata;
    end
  end

  always_ff @(posedge clk_5m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q     <= '0;
      scratch_q <= '0;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
    end
  end

  // Read mux reflects current flop contents, so a load in a store cycle
  // returns the value from before the store.
  always_comb begin
    mem_rdata = '0;
    if (hit) begin
      case (ofs)
        OFS_LED:     mem_rdata[LED_W-1:0] = led_q;
        OFS_SCRATCH: mem_rdata = scratch_q;
`ifdef IO_TIMER_EN
        OFS_CTRL:    mem_rdata = ctrl_rd;
        OFS_CNT:     mem_rdata = cnt_rd;
        OFS_CMP:     mem_rdata = cmp_rd;
        OFS_STAT:    mem_rdata = stat_rd;
`endif
        default:     mem_rdata = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed bench for mmio_io_ctrl.
// Driver tasks issue one bus cycle each (inputs change 1 time unit after
// the rising edge) and push the expected response; a monitor samples on
// the falling edge whenever a check is requested and pops the queue.
// Timer scenarios run when IO_TIMER_EN is defined; otherwise the bench
// checks that the timer offsets are inert.
module tb_mmio_io_ctrl;

  localparam int LED_W = 8;

  localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CTRL = 32'hFFFF_FF04;
  localparam logic [31:0] A_CNT  = 32'hFFFF_FF08;
  localparam logic [31:0] A_CMP  = 32'hFFFF_FF0C;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF10;
  localparam logic [31:0] A_SCR  = 32'hFFFF_FF14;

  localparam int K_RD  = 0;  // compare mem_rdata
  localparam int K_LED = 1;  // compare led output
  localparam int K_IRQ = 2;  // compare timer_irq

  // ---------------- clock / reset ----------------
  logic             clk_5m    = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [31:0]      mem_addr  = '0;
  logic [31:0]      mem_wdata = '0;
  logic             mem_we    = 1'b0;
  logic [31:0]      mem_rdata;
  logic [LED_W-1:0] led;
  logic             timer_irq;

  always #100 clk_5m = ~clk_5m;

  mmio_io_ctrl #(
    .IO_BASE (32'hFFFF_FF00),
    .LED_W   (LED_W)
  ) dut (
    .clk_5m    (clk_5m),
    .sys_rst_n (sys_rst_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .led       (led),
    .timer_irq (timer_irq)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          kind_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        chk_req = 1'b0;

  logic [31:0] mon_exp;
  logic [31:0] mon_got;
  logic [31:0] mon_addr;
  int          mon_kind;

  function automatic string kind_name(input int k);
    case (k)
      K_LED:   return "led";
      K_IRQ:   return "timer_irq";
      default: return "mem_rdata";
    endcase
  endfunction

  always @(negedge clk_5m) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: check requested with no expected value");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_addr = addr_q.pop_front();
        case (mon_kind)
          K_LED:   mon_got = {{(32-LED_W){1'b0}}, led};
          K_IRQ:   mon_got = {31'b0, timer_irq};
          default: mon_got = mem_rdata;
        endcase
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL %s addr=%h at %0t: got %h, expected %h",
                   kind_name(mon_kind), mon_addr, $time, mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each task is entered 1 time unit after a rising edge and returns
  // 1 time unit after the next rising edge.
  task automatic push_exp(input int k, input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    kind_q.push_back(k);
    addr_q.push_back(a);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    chk_req   = 1'b0;
    @(posedge clk_5m);
    #1;
    mem_we    = 1'b0;
  endtask

  // Store with a check sampled during the store cycle itself.
  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d,
                        input int k, input logic [31:0] e);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    push_exp(k, a, e);
    chk_req   = 1'b1;
    @(posedge clk_5m);
    #1;
    mem_we    = 1'b0;
    chk_req   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input int k, input logic [31:0] e);
    mem_addr = a;
    mem_we   = 1'b0;
    push_exp(k, a, e);
    chk_req  = 1'b1;
    @(posedge clk_5m);
    #1;
    chk_req  = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: stimulus did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk_5m);
    #1;
    sys_rst_n = 1'b1;

    // Reset state
    rd(A_LED, K_RD, 32'h0);
    rd(A_SCR, K_RD, 32'h0);
    rd(A_LED, K_LED, 32'h0);
    rd(A_LED, K_IRQ, 32'h0);
`ifdef IO_TIMER_EN
    rd(A_CTRL, K_RD, 32'h0);
    rd(A_CNT,  K_RD, 32'h0);
    rd(A_CMP,  K_RD, 32'h0);
    rd(A_STAT, K_RD, 32'h0);
`endif

    // LED store/load; led must not change before the store edge
    wr_chk(A_LED, 32'h0000_00A5, K_LED, 32'h0);
    rd(A_LED, K_LED, 32'h0000_00A5);
    rd(A_LED, K_RD,  32'h0000_00A5);
    wr_chk(A_LED, 32'hFFFF_FF3C, K_RD, 32'h0000_00A5);  // pre-write value
    rd(A_LED, K_LED, 32'h0000_003C);
    rd(A_LED, K_RD,  32'h0000_003C);

    // Decode misses
    wr(32'hFFFF_FE00, 32'h1234_5678);
    wr(32'hFFFF_FF02, 32'h1234_5678);
    rd(A_LED, K_LED, 32'h0000_003C);
    rd(A_LED, K_RD,  32'h0000_003C);
    rd(32'hFFFF_FE00, K_RD, 32'h0);
    rd(32'hFFFF_FF02, K_RD, 32'h0);
    rd(32'hFFFF_FF18, K_RD, 32'h0);
    rd(A_SCR, K_RD, 32'h0);

    // SCRATCH
    wr(A_SCR, 32'hDEAD_BEEF);
    rd(A_SCR, K_RD, 32'hDEAD_BEEF);
    wr(32'hFFFF_FE14, 32'h0);
    rd(A_SCR, K_RD, 32'hDEAD_BEEF);

`ifdef IO_TIMER_EN
    // Auto-reload: CMP=3, PRESC=2 -> match 12 cycles after the CTRL edge
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h0000_0207);
    for (int i = 0; i < 11; i++) rd(A_STAT, K_RD, 32'h0);  // cycles 0..10
    rd(A_STAT, K_IRQ, 32'h0);                               // cycle 11
    rd(A_STAT, K_IRQ, 32'h1);                               // cycle 12
    rd(A_STAT, K_RD, 32'h1);
    rd(A_CNT,  K_RD, 32'h0);
    wr(A_STAT, 32'h1);
    rd(A_STAT, K_IRQ, 32'h0);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);

    // One-shot: CMP=0, PRESC=0
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h0);
    wr(A_CTRL, 32'h1);
    rd(A_STAT, K_RD, 32'h0);
    rd(A_STAT, K_RD, 32'h1);
    rd(A_CTRL, K_RD, 32'h0);
    rd(A_CNT,  K_RD, 32'h0);
    rd(A_CNT,  K_IRQ, 32'h0);
    // CTRL write in the cycle the one-shot would clear EN
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, K_RD, 32'h1);
    rd(A_CTRL, K_RD, 32'h0);
    // W1C in the same cycle as a rematch
    wr(A_CTRL, 32'h1);
    wr(A_STAT, 32'h1);
    rd(A_STAT, K_RD, 32'h1);
    wr(A_STAT, 32'h1);
    rd(A_STAT, K_RD, 32'h0);

    // Wrap and CNT load
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h3);
    rd(A_CNT, K_RD, 32'hFFFF_FFFE);
    rd(A_CNT, K_RD, 32'hFFFF_FFFF);
    rd(A_CNT, K_RD, 32'h0);
    for (int i = 0; i < 5; i++) rd(A_STAT, K_RD, 32'h0);
    rd(A_STAT, K_RD, 32'h1);
    rd(A_CNT,  K_RD, 32'h1);
    wr(A_CNT, 32'h0000_0100);      // coincides with a tick
    rd(A_CNT, K_RD, 32'h0000_0100);
    rd(A_CNT, K_RD, 32'h0000_0101);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);

    // Running timer with interrupt before reset
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h7);
    rd(A_CNT, K_RD, 32'h0);
    rd(A_CNT, K_RD, 32'h1);
    rd(A_CNT, K_IRQ, 32'h0);
    rd(A_CNT, K_IRQ, 32'h1);
`else
    // Timer absent: offsets inert, interrupt tied low
    wr(A_CTRL, 32'h7);
    rd(A_CTRL, K_RD, 32'h0);
    wr(A_CNT, 32'h5);
    rd(A_CNT, K_RD, 32'h0);
    wr(A_CMP, 32'h3);
    rd(A_CMP, K_RD, 32'h0);
    wr(A_STAT, 32'h1);
    rd(A_STAT, K_RD, 32'h0);
    rd(A_LED, K_IRQ, 32'h0);
`endif

    // Asynchronous reset mid-operation: first check lands before any edge
    sys_rst_n = 1'b0;
    rd(A_LED, K_LED, 32'h0);
    rd(A_LED, K_IRQ, 32'h0);
    rd(A_SCR, K_RD, 32'h0);
`ifdef IO_TIMER_EN
    rd(A_CNT,  K_RD, 32'h0);
    rd(A_CTRL, K_RD, 32'h0);
    rd(A_STAT, K_RD, 32'h0);
`endif
    sys_rst_n = 1'b1;
    rd(A_LED, K_RD, 32'h0);
`ifdef IO_TIMER_EN
    rd(A_CNT, K_RD, 32'h0);
    rd(A_CNT, K_RD, 32'h0);
`else
    wr(A_CTRL, 32'h7);
    rd(A_CTRL, K_RD, 32'h0);
`endif

    repeat (2) @(posedge clk_5m);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
